// File: rtl/instruction_decode.sv
// ID stage: decode, 32-entry register file, sign extension, load-use stall, ID/EX register.
// Optional write-before-read forwarding into the ID/EX operands under `REGFILE_BYPASS_EN.
module instruction_decode #(
  parameter int XLEN             = 32,
  parameter int NREGS            = 32,
  parameter int RESET_INIT_INDEX = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pcSrc,
  input  logic [31:0]     pc_out1_s1,
  input  logic [31:0]     instruction_s1,
  input  logic            reg_write_s5,
  input  logic [4:0]      write_reg_s5,
  input  logic [XLEN-1:0] write_data_s5,
  output logic            stall,
  output logic [31:0]     pc_out1_s2,
  output logic [XLEN-1:0] read_data1_s2,
  output logic [XLEN-1:0] read_data2_s2,
  output logic [XLEN-1:0] sign_ext_imm_s2,
  output logic [4:0]      rs_s2,
  output logic [4:0]      rt_s2,
  output logic [4:0]      rd_s2,
  output logic            reg_write_s2,
  output logic            mem_read_s2,
  output logic            mem_write_s2,
  output logic            mem_to_reg_s2,
  output logic            branch_s2,
  output logic            alu_src_s2,
  output logic            reg_dst_s2,
  output logic [3:0]      alu_op_s2
);
  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b100011, OP_LW = 6'b101011,
                         OP_ST = 6'b000100, OP_BEQ = 6'b000101;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src;
    logic       reg_dst;
    logic [3:0] alu_op;
  } ctrl_t;

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  assign opcode = instruction_s1[31:26];
  assign rs     = instruction_s1[25:21];
  assign rt     = instruction_s1[20:16];
  assign rd     = instruction_s1[15:11];
  assign funct  = instruction_s1[5:0];

  ctrl_t ctrl_dec, ctrl_d, ctrl_q;

  always_comb begin
    ctrl_dec = '0;
    case (opcode)
      OP_R: begin
        case (funct)
          6'b100000: ctrl_dec.alu_op = 4'd1;
          6'b100010: ctrl_dec.alu_op = 4'd2;
          6'b011011: ctrl_dec.alu_op = 4'd3;
          6'b001010: ctrl_dec.alu_op = 4'd4;
          default:   ctrl_dec.alu_op = 4'd0;
        endcase
        // unknown funct (including the all-zero word) stays a bubble
        if (ctrl_dec.alu_op != 4'd0) begin
          ctrl_dec.reg_write = 1'b1;
          ctrl_dec.reg_dst   = 1'b1;
        end
      end
      OP_ADDI: begin
        ctrl_dec.reg_write = 1'b1; ctrl_dec.alu_src = 1'b1; ctrl_dec.alu_op = 4'd1;
      end
      OP_LW: begin
        ctrl_dec.reg_write = 1'b1; ctrl_dec.mem_read = 1'b1; ctrl_dec.mem_to_reg = 1'b1;
        ctrl_dec.alu_src   = 1'b1; ctrl_dec.alu_op   = 4'd1;
      end
      OP_ST: begin
        ctrl_dec.mem_write = 1'b1; ctrl_dec.alu_src = 1'b1; ctrl_dec.alu_op = 4'd1;
      end
      OP_BEQ: begin
        ctrl_dec.branch = 1'b1; ctrl_dec.alu_op = 4'd5;
      end
      default: ctrl_dec = '0;
    endcase
  end

  logic uses_rt;
  assign uses_rt = (opcode == OP_R) || (opcode == OP_ST) || (opcode == OP_BEQ);
  assign stall   = ctrl_q.mem_read && (rt_s2 != 5'd0) &&
                   ((rt_s2 == rs) || ((rt_s2 == rt) && uses_rt)) && !pcSrc;

  assign ctrl_d = (pcSrc || stall) ? '0 : ctrl_dec;

  // Register file
  logic [XLEN-1:0] regs_q [NREGS];
  logic            wb_en;
  assign wb_en = reg_write_s5 && (write_reg_s5 != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= (RESET_INIT_INDEX != 0) ? XLEN'(i) : '0;
    end else if (wb_en) begin
      regs_q[write_reg_s5] <= write_data_s5;
    end
  end

  logic [XLEN-1:0] rd1_d, rd2_d;
  always_comb begin
    rd1_d = (rs == 5'd0) ? '0 : regs_q[rs];
    rd2_d = (rt == 5'd0) ? '0 : regs_q[rt];
`ifdef REGFILE_BYPASS_EN
    if (wb_en && (write_reg_s5 == rs)) rd1_d = write_data_s5;
    if (wb_en && (write_reg_s5 == rt)) rd2_d = write_data_s5;
`endif
  end

  // ID/EX register
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q          <= '0;
      pc_out1_s2      <= '0;
      read_data1_s2   <= '0;
      read_data2_s2   <= '0;
      sign_ext_imm_s2 <= '0;
      rs_s2           <= '0;
      rt_s2           <= '0;
      rd_s2           <= '0;
    end else begin
      ctrl_q          <= ctrl_d;
      pc_out1_s2      <= pc_out1_s1;
      read_data1_s2   <= rd1_d;
      read_data2_s2   <= rd2_d;
      sign_ext_imm_s2 <= {{(XLEN-16){instruction_s1[15]}}, instruction_s1[15:0]};
      rs_s2           <= rs;
      rt_s2           <= rt;
      rd_s2           <= rd;
    end
  end

  assign reg_write_s2  = ctrl_q.reg_write;
  assign mem_read_s2   = ctrl_q.mem_read;
  assign mem_write_s2  = ctrl_q.mem_write;
  assign mem_to_reg_s2 = ctrl_q.mem_to_reg;
  assign branch_s2     = ctrl_q.branch;
  assign alu_src_s2    = ctrl_q.alu_src;
  assign reg_dst_s2    = ctrl_q.reg_dst;
  assign alu_op_s2     = ctrl_q.alu_op;
endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Stage 2 of the 5-stage RISC pipeline. Consumes the IF/ID register (pc_out1_s1, instruction_s1) produced by the fetch stage.
- Decodes the instruction, reads the 32x32 register file, sign-extends the immediate and registers everything into the ID/EX register (*_s2).
- Detects load-use hazards and drives a stall back to fetch; inserts a bubble on branch flush (pcSrc).
- Hosts the register file write port driven from write-back (*_s5).

Parameters:
- XLEN, 32, datapath and register width.
- NREGS, 32, number of architectural registers (5-bit specifiers).
- RESET_INIT_INDEX, 1, when 1 register i resets to value i; when 0 all registers reset to 0.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high.
- pcSrc  in  1  branch taken in stage 3; flush.
- pc_out1_s1  in  32  PC+4 from IF/ID.
- instruction_s1  in  32  instruction from IF/ID.
- reg_write_s5  in  1  write-back enable.
- write_reg_s5  in  5  write-back destination.
- write_data_s5  in  32  write-back data.
- stall  out  1  combinational; 1 = fetch holds PC and IF/ID.
- pc_out1_s2  out  32  registered PC+4.
- read_data1_s2, read_data2_s2  out  32  registered rs/rt operands.
- sign_ext_imm_s2  out  32  registered sign-extended instr[15:0].
- rs_s2, rt_s2, rd_s2  out  5  registered specifiers.
- reg_write_s2, mem_read_s2, mem_write_s2, mem_to_reg_s2, branch_s2, alu_src_s2, reg_dst_s2  out  1 each  registered controls.
- alu_op_s2  out  4  0=NONE 1=ADD 2=SUB 3=MULT 4=AND 5=CMP.

Behaviour:
- Fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm [15:0].
- Decode by opcode:
  - 000000 R-type: reg_write=1, reg_dst=1; alu_op from funct: 100000 ADD, 100010 SUB, 011011 MULT, 001010 AND. Any other funct gives a bubble.
  - 100011 ADDI: reg_write=1, alu_src=1, ADD.
  - 101011 LW: reg_write=1, mem_read=1, mem_to_reg=1, alu_src=1, ADD.
  - 000100 ST: mem_write=1, alu_src=1, ADD.
  - 000101 BEQ: branch=1, CMP.
  - Other opcodes and 0x00000000 give a bubble (all controls 0, alu_op 0).
- Register file:
  - Write on the clk edge when reg_write_s5=1 and write_reg_s5!=0.
  - r0 always reads 0.
  - Reads are combinational.
- Latency: 1 cycle from IF/ID to ID/EX.
- Load-use hazard: stall = mem_read_s2 & rt_s2!=0 & (rt_s2==rs | (rt_s2==rt & opcode in {R-type, ST, BEQ})) & !pcSrc.
  - On stall, ID/EX loads a bubble. Data fields update normally.
- Edge priority: reset > pcSrc > stall > normal.
  - reset: all *_s2 outputs 0, registers re-initialised per RESET_INIT_INDEX, stall deasserts on the following cycle.
  - pcSrc: ID/EX loads a bubble (controls 0). A simultaneous write-back still commits.
- Reset mid-operation discards the in-flight ID/EX contents. Pending write-back in the same cycle is dropped (reset wins).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when reg_write_s5=1, write_reg_s5!=0 and write_reg_s5 matches rs (or rt), read_data1_s2 (or read_data2_s2) captures write_data_s5 in the same cycle (write-before-read forwarding).
- Undefined: the read returns the old register value; the new value is visible one cycle later.

Test Plan:
- Reset, then instruction_s1=0x00432020 (add r4 r3 r2), pc_out1_s1=0x4 -> next edge: read_data1_s2=2, read_data2_s2=3, rd_s2=4, alu_op_s2=1, reg_write_s2=1, reg_dst_s2=1, pc_out1_s2=0x4.
- 0xAC820001 (lw) then 0x00432020 -> stall=1 for one cycle, ID/EX controls all 0 that cycle, add issues on the next edge with stall=0; 0x00812022 (sub r4 r4 r1) after lw -> no stall.
- 0x00432020 held, reg_write_s5=1, write_reg_s5=3, write_data_s5=0xDEADBEEF -> read_data2_s2=0xDEADBEEF with REGFILE_BYPASS_EN, 3 without; the repeated read the next cycle gives 0xDEADBEEF in both builds.
- write_reg_s5=0, write_data_s5=0xFFFFFFFF, reg_write_s5=1, then read r0 -> 0.
- pcSrc=1 with 0x00432020 in IF/ID, also during a load-use stall -> ID/EX controls 0, stall=0 that cycle.
- Opcode 0x3F and 0x00000000 -> bubble; ADDI imm 0x8000 -> sign_ext_imm_s2=0xFFFF8000, alu_src_s2=1.
